// File: rtl/branch_redirect_ctrl.sv
// Branch redirect controller.
// Turns an EX-stage branch resolution into a registered one-shot PC redirect
// plus a timed IF/ID + ID/EX flush. Illegal targets raise a sticky trap.
// It also keeps saturating statistics on resolved and taken control flow.
module branch_redirect_ctrl #(
  parameter int PC_W         = 9,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ex_valid,
  input  logic             ex_branch,
  input  logic             ex_jump,
  input  logic             pc_sel,
  input  logic [31:0]      br_pc,
  input  logic             stall,
  output logic             redirect_valid,
  output logic [PC_W-1:0]  redirect_pc,
  output logic             flush_ifid,
  output logic             flush_idex,
  output logic             misalign_trap,
  output logic             busy,
  output logic [CNT_W-1:0] br_count,
  output logic [CNT_W-1:0] taken_count
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FLUSH = 2'd1,
    S_TRAP  = 2'd2
  } state_t;

  // The FLUSH counter runs from FLUSH_CYCLES-1 down to 0.
  // Three bits cover the supported range of 1..7.
  localparam logic [2:0] CNT_LOAD = 3'(FLUSH_CYCLES - 1);

  state_t           state_q, state_d;
  logic [2:0]       cnt_q, cnt_d;
  logic             rv_q, rv_d;
  logic [PC_W-1:0]  rpc_q, rpc_d;
  logic             flush_q, flush_d;
  logic             trap_q, trap_d;
  logic [CNT_W-1:0] br_q, br_d;
  logic [CNT_W-1:0] tk_q, tk_d;

  logic cf;
  logic acc;
  logic legal;

  // A control-flow instruction only counts when it is real, unstalled, and
  // actually a branch or jump. pc_sel alone never triggers anything.
  assign cf    = ex_valid & (ex_branch | ex_jump) & ~stall;
  assign acc   = cf & pc_sel;
  // The target must be word aligned and lie inside the PC_W address space.
  assign legal = (br_pc[1:0] == 2'b00) && ((br_pc >> PC_W) == 32'd0);

  // Next-state, output, and counter logic. The redirect is a one-cycle pulse.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rv_d    = 1'b0;
    rpc_d   = rpc_q;
    flush_d = flush_q;
    trap_d  = trap_q;
    br_d    = br_q;
    tk_d    = tk_q;
    case (state_q)
      S_IDLE: begin
        flush_d = 1'b0;
        if (cf && (br_q != {CNT_W{1'b1}})) begin
          br_d = br_q + CNT_W'(1);
        end
        if (acc) begin
          if (legal) begin
            rv_d    = 1'b1;
            rpc_d   = br_pc[PC_W-1:0];
            flush_d = 1'b1;
            cnt_d   = CNT_LOAD;
            state_d = S_FLUSH;
            if (tk_q != {CNT_W{1'b1}}) begin
              tk_d = tk_q + CNT_W'(1);
            end
          end else begin
            trap_d  = 1'b1;
            flush_d = 1'b1;
            state_d = S_TRAP;
          end
        end
      end
      S_FLUSH: begin
        // Instructions in EX are wrong-path here, so pc_sel and cf are ignored.
        // A stall freezes the countdown, which stretches the flush.
        flush_d = 1'b1;
        if (!stall) begin
          if (cnt_q == 3'd0) begin
            flush_d = 1'b0;
            state_d = S_IDLE;
          end else begin
            cnt_d = cnt_q - 3'd1;
          end
        end
      end
      S_TRAP: begin
        trap_d  = 1'b1;
        flush_d = 1'b1;
      end
      default: begin
        state_d = S_IDLE;
        flush_d = 1'b0;
      end
    endcase
  end

  // State and output registers. Reset wins over everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 3'd0;
      rv_q    <= 1'b0;
      rpc_q   <= '0;
      flush_q <= 1'b0;
      trap_q  <= 1'b0;
      br_q    <= '0;
      tk_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rv_q    <= rv_d;
      rpc_q   <= rpc_d;
      flush_q <= flush_d;
      trap_q  <= trap_d;
      br_q    <= br_d;
      tk_q    <= tk_d;
    end
  end

  assign redirect_valid = rv_q;
  assign redirect_pc    = rpc_q;
  assign flush_ifid     = flush_q;
  assign flush_idex     = flush_q;
  assign misalign_trap  = trap_q;
  assign busy           = (state_q != S_IDLE);
  assign br_count       = br_q;
  assign taken_count    = tk_q;

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Self-checking bench for branch_redirect_ctrl.
// A fixed vector table covers the directed corner cases. A random phase then
// runs against a behavioural model. A second instance with 4-bit counters
// shares the same stimulus and is used for the saturation checks.
module tb_branch_redirect_ctrl;

  logic        clk = 1'b0;
  logic        reset, ex_valid, ex_branch, ex_jump, pc_sel, stall;
  logic [31:0] br_pc;

  logic        redirect_valid, flush_ifid, flush_idex, misalign_trap, busy;
  logic [8:0]  redirect_pc;
  logic [15:0] br_count, taken_count;

  logic        rv4, fi4, fe4, tr4, bs4;
  logic [8:0]  rpc4;
  logic [3:0]  br4, tk4;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  branch_redirect_ctrl #(.PC_W(9), .FLUSH_CYCLES(2), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_branch(ex_branch),
    .ex_jump(ex_jump), .pc_sel(pc_sel), .br_pc(br_pc), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .flush_ifid(flush_ifid), .flush_idex(flush_idex),
    .misalign_trap(misalign_trap), .busy(busy),
    .br_count(br_count), .taken_count(taken_count)
  );

  branch_redirect_ctrl #(.PC_W(9), .FLUSH_CYCLES(2), .CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_branch(ex_branch),
    .ex_jump(ex_jump), .pc_sel(pc_sel), .br_pc(br_pc), .stall(stall),
    .redirect_valid(rv4), .redirect_pc(rpc4),
    .flush_ifid(fi4), .flush_idex(fe4),
    .misalign_trap(tr4), .busy(bs4),
    .br_count(br4), .taken_count(tk4)
  );

  typedef struct {
    logic        rst, v, b, j, ps, stl;
    logic [31:0] pc;
    logic        rv;
    logic [8:0]  rpc;
    logic        fl, tr, bsy;
    int          br, tk;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic rst, logic v, logic b, logic j, logic ps,
                              logic stl, logic [31:0] pc, logic rv,
                              logic [8:0] rpc, logic fl, logic tr, logic bsy,
                              int br, int tk);
    vec_t r;
    r.rst = rst; r.v = v; r.b = b; r.j = j; r.ps = ps; r.stl = stl; r.pc = pc;
    r.rv = rv; r.rpc = rpc; r.fl = fl; r.tr = tr; r.bsy = bsy;
    r.br = br; r.tk = tk;
    return r;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  function automatic int sat(int x, int mx);
    return (x > mx) ? mx : x;
  endfunction

  task automatic check_all(string tag, logic rv, logic [8:0] rpc, logic fl,
                           logic tr, logic bsy, int br, int tk);
    chk({tag, ".redirect_valid"}, 32'(redirect_valid), 32'(rv));
    chk({tag, ".redirect_pc"},    32'(redirect_pc),    32'(rpc));
    chk({tag, ".flush_ifid"},     32'(flush_ifid),     32'(fl));
    chk({tag, ".flush_idex"},     32'(flush_idex),     32'(fl));
    chk({tag, ".misalign_trap"},  32'(misalign_trap),  32'(tr));
    chk({tag, ".busy"},           32'(busy),           32'(bsy));
    chk({tag, ".br_count"},       32'(br_count),       32'(sat(br, 65535)));
    chk({tag, ".taken_count"},    32'(taken_count),    32'(sat(tk, 65535)));
    chk({tag, ".br_count4"},      32'(br4),            32'(sat(br, 15)));
    chk({tag, ".taken_count4"},   32'(tk4),            32'(sat(tk, 15)));
  endtask

  task automatic drive(logic rst, logic v, logic b, logic j, logic ps,
                       logic stl, logic [31:0] pc);
    reset = rst; ex_valid = v; ex_branch = b; ex_jump = j;
    pc_sel = ps; stall = stl; br_pc = pc;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Behavioural model. flush_left counts the unstalled flush cycles still
  // owed, and trap is sticky until reset.
  int         m_left, m_br, m_tk;
  bit         m_trap, m_rv;
  logic [8:0] m_rpc;

  task automatic model_step();
    bit is_cf;
    m_rv = 1'b0;
    if (reset) begin
      m_left = 0; m_trap = 1'b0; m_rpc = '0; m_br = 0; m_tk = 0;
    end else if (m_trap) begin
      // stuck until reset
    end else if (m_left > 0) begin
      if (!stall) m_left = m_left - 1;
    end else begin
      is_cf = ex_valid && (ex_branch || ex_jump) && !stall;
      if (is_cf) m_br = m_br + 1;
      if (is_cf && pc_sel) begin
        if ((br_pc % 4 == 0) && (br_pc < 32'd512)) begin
          m_tk   = m_tk + 1;
          m_rv   = 1'b1;
          m_rpc  = br_pc[8:0];
          m_left = 2;
        end else begin
          m_trap = 1'b1;
        end
      end
    end
  endtask

  task automatic model_tick(string tag);
    model_step();
    tick();
    check_all(tag, m_rv, m_rpc, m_trap || (m_left > 0), m_trap,
              m_trap || (m_left > 0), m_br, m_tk);
  endtask

  initial begin
    //            rst v b j ps st pc            | rv rpc    fl tr bs br tk
    tbl.push_back(mk(1,0,0,0,0,0,32'h0,          0,9'h000, 0,0,0, 0,0));
    tbl.push_back(mk(1,0,0,0,0,0,32'h0,          0,9'h000, 0,0,0, 0,0));
    tbl.push_back(mk(0,0,0,0,0,0,32'h0,          0,9'h000, 0,0,0, 0,0));
    tbl.push_back(mk(0,1,1,0,1,0,32'h40,         1,9'h040, 1,0,1, 1,1));
    tbl.push_back(mk(0,1,1,0,1,0,32'h80,         0,9'h040, 1,0,1, 1,1));
    tbl.push_back(mk(0,0,0,0,0,0,32'h0,          0,9'h040, 0,0,0, 1,1));
    tbl.push_back(mk(1,0,0,0,0,0,32'h0,          0,9'h000, 0,0,0, 0,0));
    for (int k = 1; k <= 5; k++)
      tbl.push_back(mk(0,1,1,0,0,0,32'h40,       0,9'h000, 0,0,0, k,0));
    tbl.push_back(mk(0,1,0,0,1,0,32'h40,         0,9'h000, 0,0,0, 5,0));
    tbl.push_back(mk(0,0,1,0,1,0,32'h40,         0,9'h000, 0,0,0, 5,0));
    for (int k = 0; k < 3; k++)
      tbl.push_back(mk(0,1,0,1,1,1,32'h100,      0,9'h000, 0,0,0, 5,0));
    tbl.push_back(mk(0,1,0,1,1,0,32'h100,        1,9'h100, 1,0,1, 6,1));
    tbl.push_back(mk(0,0,0,0,0,1,32'h0,          0,9'h100, 1,0,1, 6,1));
    tbl.push_back(mk(0,0,0,0,0,0,32'h0,          0,9'h100, 1,0,1, 6,1));
    tbl.push_back(mk(0,0,0,0,0,0,32'h0,          0,9'h100, 0,0,0, 6,1));
    tbl.push_back(mk(0,1,1,0,1,0,32'h1FC,        1,9'h1FC, 1,0,1, 7,2));
    tbl.push_back(mk(0,0,0,0,0,0,32'h0,          0,9'h1FC, 1,0,1, 7,2));
    tbl.push_back(mk(0,0,0,0,0,0,32'h0,          0,9'h1FC, 0,0,0, 7,2));
    tbl.push_back(mk(0,1,1,0,1,0,32'h42,         0,9'h1FC, 1,1,1, 8,2));
    tbl.push_back(mk(0,1,1,0,1,0,32'h40,         0,9'h1FC, 1,1,1, 8,2));
    tbl.push_back(mk(0,1,1,0,1,0,32'h40,         0,9'h1FC, 1,1,1, 8,2));
    tbl.push_back(mk(1,0,0,0,0,0,32'h0,          0,9'h000, 0,0,0, 0,0));
    tbl.push_back(mk(0,1,1,0,1,0,32'h400,        0,9'h000, 1,1,1, 1,0));
    tbl.push_back(mk(0,0,0,0,0,0,32'h0,          0,9'h000, 1,1,1, 1,0));
    tbl.push_back(mk(1,0,0,0,0,0,32'h0,          0,9'h000, 0,0,0, 0,0));
    tbl.push_back(mk(0,1,0,1,1,0,32'h40,         1,9'h040, 1,0,1, 1,1));
    for (int k = 0; k < 3; k++)
      tbl.push_back(mk(1,1,1,0,1,0,32'h40,       0,9'h000, 0,0,0, 0,0));
    tbl.push_back(mk(0,0,0,0,0,0,32'h0,          0,9'h000, 0,0,0, 0,0));

    drive(1, 0, 0, 0, 0, 0, 32'h0);
    tick();

    // Directed vectors, each showing the outputs one cycle after its inputs.
    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].v, tbl[i].b, tbl[i].j, tbl[i].ps,
            tbl[i].stl, tbl[i].pc);
      tick();
      $display("vec %0d: rst=%0b v=%0b b=%0b j=%0b ps=%0b st=%0b pc=%h -> rv=%0b rpc=%h fl=%0b tr=%0b busy=%0b br=%0d tk=%0d",
               i, tbl[i].rst, tbl[i].v, tbl[i].b, tbl[i].j, tbl[i].ps,
               tbl[i].stl, tbl[i].pc, redirect_valid, redirect_pc,
               flush_ifid, misalign_trap, busy, br_count, taken_count);
      check_all($sformatf("vec%0d", i), tbl[i].rv, tbl[i].rpc, tbl[i].fl,
                tbl[i].tr, tbl[i].bsy, tbl[i].br, tbl[i].tk);
    end

    // Saturation: 20 taken branches back to back, with wrong-path pc_sel
    // asserted during each flush.
    drive(1, 0, 0, 0, 0, 0, 32'h0);
    model_tick("sat_rst");
    for (int n = 0; n < 20; n++) begin
      drive(0, 1, 1, 0, 1, 0, 32'(n * 4));
      model_tick("sat_acc");
      drive(0, 1, 0, 1, 1, 0, 32'h8);
      model_tick("sat_fl1");
      model_tick("sat_fl2");
      $display("sat %0d: br=%0d tk=%0d br4=%0d tk4=%0d",
               n, br_count, taken_count, br4, tk4);
    end
    chk("sat.br_count4", 32'(br4), 32'd15);
    chk("sat.taken_count4", 32'(tk4), 32'd15);
    chk("sat.br_count", 32'(br_count), 32'd20);
    chk("sat.taken_count", 32'(taken_count), 32'd20);

    // Random traffic against the model.
    for (int c = 0; c < 1500; c++) begin
      logic [31:0] pc;
      int sel;
      sel = int'($urandom_range(0, 19));
      if (sel < 16)      pc = {23'd0, 7'($urandom), 2'b00};
      else if (sel < 18) pc = {23'd0, 7'($urandom), 2'($urandom_range(1, 3))};
      else               pc = $urandom | 32'h200;
      drive($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 85,
            1'($urandom), 1'($urandom), 1'($urandom),
            $urandom_range(0, 3) == 0, pc);
      model_tick("rand");
      $display("rand %0d: rst=%0b v=%0b b=%0b j=%0b ps=%0b st=%0b pc=%h -> rv=%0b rpc=%h fl=%0b tr=%0b br=%0d tk=%0d",
               c, reset, ex_valid, ex_branch, ex_jump, pc_sel, stall, br_pc,
               redirect_valid, redirect_pc, flush_ifid, misalign_trap,
               br_count, taken_count);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
